channel_sequencer: RTL and testbench
====================================

CHANNEL_SEQUENCER -- requirements
Module: channel_sequencer

Interface
REQ-001 The module SHALL have parameter DWELL_WIDTH, default 8, giving the width of the settle-time counter.
REQ-002 The module SHALL have parameter NUM_OF_SEL_BITS, default 4, giving the width of the one-hot select bus; only 4 is supported.
REQ-003 CLK  input  1  sole clock; all state SHALL change on the rising edge.
REQ-004 RST_N  input  1  reset; synchronous and active-low.
REQ-005 START  input  1  begin sequencing; sampled in IDLE only.
REQ-006 STOP  input  1  request return to IDLE; sampled in any non-IDLE state.
REQ-007 CH_EN  input  4  channel enable mask; bit n enables channel n+1.
REQ-008 DWELL  input  DWELL_WIDTH  settle cycles after a select change, minus one.
REQ-009 SAMPLE_READY  input  1  downstream accepts the current sample.
REQ-010 SEL  output  4  registered one-hot select to the 4-input one-hot multiplexer; 4'b0000 means no input selected.
REQ-011 CH_IDX  output  2  binary index of the asserted SEL bit, or 0 when SEL is 0.
REQ-012 SAMPLE_VALID  output  1  the multiplexer output is settled and presentable.
REQ-013 BUSY  output  1  high in every state except IDLE.
REQ-014 FRAME_DONE  output  1  one-cycle pulse when the last enabled channel of a frame is accepted.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SETTLE and SAMPLE.
REQ-016 In IDLE, START=1 with CH_EN!=0 SHALL:
  - latch CH_EN into an internal mask;
  - set SEL to the lowest enabled channel;
  - load the counter with DWELL;
  - enter SETTLE on the next edge.
REQ-017 In IDLE, START=1 with CH_EN=0 SHALL be ignored; the FSM stays in IDLE.
REQ-018 In SETTLE, the counter SHALL decrement each cycle; the transition to SAMPLE SHALL occur on the edge where the counter equals 0, so SETTLE lasts DWELL+1 cycles.
REQ-019 In SAMPLE, SAMPLE_VALID SHALL be 1 and SHALL hold, with SEL stable, until a cycle with SAMPLE_READY=1 (the handshake).
REQ-020 On a handshake, SEL SHALL advance to the next enabled channel of the latched mask in ascending order, wrapping from channel 4 to channel 1, the counter SHALL reload DWELL, and the FSM SHALL enter SETTLE.
REQ-021 A handshake on the highest enabled channel of the latched mask SHALL:
  - pulse FRAME_DONE for that cycle;
  - re-latch CH_EN as the new mask;
  - select the lowest enabled channel of the new mask.
REQ-022 If CH_EN is 0 at a frame wrap, the FSM SHALL go to IDLE with SEL=0.
REQ-023 If exactly one channel is enabled, every handshake SHALL re-select the same channel, pulse FRAME_DONE and re-enter SETTLE.
REQ-024 STOP=1 in SETTLE SHALL return the FSM to IDLE on the next edge with SEL=0 and no SAMPLE_VALID.
REQ-025 STOP=1 in SAMPLE SHALL be latched; the FSM SHALL go to IDLE (SEL=0) after the next handshake, and FRAME_DONE SHALL still pulse if that handshake is end-of-frame.
REQ-026 STOP and START arriving together in IDLE SHALL be treated as START only.
REQ-027 CH_EN changes within a frame SHALL have no effect until the next frame wrap.
REQ-028 SEL SHALL never have more than one bit set.
REQ-029 SAMPLE_VALID SHALL be 0 outside SAMPLE.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 With RST_N=0 at a rising edge, the module SHALL set:
  - FSM to IDLE;
  - SEL=0, CH_IDX=0;
  - SAMPLE_VALID=0, BUSY=0, FRAME_DONE=0;
  - counter, mask and stop latch to 0.
REQ-032 Reset SHALL take priority over all other inputs, including mid-SETTLE or mid-SAMPLE, with no handshake or FRAME_DONE generated.

Verification
REQ-033 Full frame: CH_EN=4'b1111, DWELL=2, START pulse, SAMPLE_READY=1 constant -> SEL steps 0001,0010,0100,1000,0001; each SETTLE lasts 3 cycles; SAMPLE_VALID is 1 for 1 cycle per channel; FRAME_DONE pulses on the 1000 handshake.
REQ-034 Sparse mask with backpressure: CH_EN=4'b1010, DWELL=0, SAMPLE_READY held 0 for 5 cycles in SAMPLE -> SEL=0010 and SAMPLE_VALID=1 held stable for the 5 cycles; after ready, SEL=1000, then wraps to 0010 with a FRAME_DONE pulse.
REQ-035 Stop during SAMPLE: STOP pulsed while SAMPLE_VALID=1 and SAMPLE_READY=0, ready given 3 cycles later -> one handshake occurs, then IDLE with SEL=0000 and BUSY=0.
REQ-036 Mask change at wrap: CH_EN changed from 1111 to 0000 on channel 2 -> channels 3 and 4 still sampled; at the wrap FRAME_DONE pulses and the FSM goes to IDLE with SEL=0.
REQ-037 Reset mid-SETTLE: RST_N=0 for one cycle during SETTLE with DWELL=200 -> all outputs are 0 on the next cycle; a subsequent START restarts from the lowest enabled channel.
REQ-038 Invalid start: START with CH_EN=0 -> BUSY stays 0 and SEL stays 0000.

Source files
------------

// File: rtl/channel_sequencer.sv
// Walks a one-hot multiplexer select through the enabled channels, waits a
// programmable settle time after each change, then offers the settled sample.
module channel_sequencer #(
  parameter int DWELL_WIDTH     = 8,
  parameter int NUM_OF_SEL_BITS = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       START,
  input  logic                       STOP,
  input  logic [NUM_OF_SEL_BITS-1:0] CH_EN,
  input  logic [DWELL_WIDTH-1:0]     DWELL,
  input  logic                       SAMPLE_READY,
  output logic [NUM_OF_SEL_BITS-1:0] SEL,
  output logic [1:0]                 CH_IDX,
  output logic                       SAMPLE_VALID,
  output logic                       BUSY,
  output logic                       FRAME_DONE,
  output logic [1:0]                 DBG_STATE
);

  // Handshake: a sample transfers on any rising edge where SAMPLE_VALID and
  // SAMPLE_READY are both 1; once raised, SAMPLE_VALID and SEL hold until then.

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [NUM_OF_SEL_BITS-1:0] sel_q, sel_d;
  logic [NUM_OF_SEL_BITS-1:0] mask_q, mask_d;
  logic [DWELL_WIDTH-1:0]     cnt_q, cnt_d;
  logic                       stop_q, stop_d;
  logic                       done_d;
  logic                       done_q;
  logic                       valid_q;
  logic                       busy_q;
  logic [1:0]                 idx_q;
  logic [NUM_OF_SEL_BITS-1:0] next_sel;
  logic                       handshake;

  function automatic logic [NUM_OF_SEL_BITS-1:0] lowest_bit(
    input logic [NUM_OF_SEL_BITS-1:0] m
  );
    logic [NUM_OF_SEL_BITS-1:0] r;
    r = '0;
    for (int i = NUM_OF_SEL_BITS - 1; i >= 0; i--) begin
      if (m[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Lowest mask bit strictly above the current select; zero means end of frame.
  function automatic logic [NUM_OF_SEL_BITS-1:0] next_above(
    input logic [NUM_OF_SEL_BITS-1:0] cur,
    input logic [NUM_OF_SEL_BITS-1:0] m
  );
    logic [NUM_OF_SEL_BITS-1:0] r;
    logic                       seen;
    logic                       found;
    r     = '0;
    seen  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < NUM_OF_SEL_BITS; i++) begin
      if (seen && m[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
      if (cur[i]) seen = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [1:0] encode(input logic [NUM_OF_SEL_BITS-1:0] s);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < NUM_OF_SEL_BITS; i++) begin
      if (s[i]) r = 2'(i);
    end
    return r;
  endfunction

  assign next_sel  = next_above(sel_q, mask_q);
  assign handshake = (state_q == S_SAMPLE) && SAMPLE_READY;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (START && (CH_EN != '0)) begin
          mask_d  = CH_EN;
          sel_d   = lowest_bit(CH_EN);
          cnt_d   = DWELL;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (STOP) begin
          state_d = S_IDLE;
          sel_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SAMPLE: begin
        if (STOP) stop_d = 1'b1;
        if (handshake) begin
          done_d = (next_sel == '0);
          // A stop raised in this same cycle still lets this transfer finish.
          if (stop_q || STOP) begin
            state_d = S_IDLE;
            sel_d   = '0;
            cnt_d   = '0;
            stop_d  = 1'b0;
          end else if (next_sel != '0) begin
            sel_d   = next_sel;
            cnt_d   = DWELL;
            state_d = S_SETTLE;
          end else begin
            mask_d = CH_EN;
            if (CH_EN == '0) begin
              state_d = S_IDLE;
              sel_d   = '0;
              cnt_d   = '0;
            end else begin
              sel_d   = lowest_bit(CH_EN);
              cnt_d   = DWELL;
              state_d = S_SETTLE;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
        cnt_d   = '0;
        stop_d  = 1'b0;
      end
    endcase
  end

  // Status outputs are decoded from next-state so they line up with SEL.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      valid_q <= (state_d == S_SAMPLE);
      busy_q  <= (state_d != S_IDLE);
      idx_q   <= encode(sel_d);
    end
  end

  assign SEL          = sel_q;
  assign CH_IDX       = idx_q;
  assign SAMPLE_VALID = valid_q;
  assign BUSY         = busy_q;
  assign FRAME_DONE   = done_q;
  assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_channel_sequencer.sv
// Self-checking bench for channel_sequencer: directed scenarios plus a random
// run, all compared against a channel-number level reference model.
module tb_channel_sequencer;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic       STOP;
  logic [3:0] CH_EN;
  logic [7:0] DWELL;
  logic       SAMPLE_READY;
  logic [3:0] SEL;
  logic [1:0] CH_IDX;
  logic       SAMPLE_VALID;
  logic       BUSY;
  logic       FRAME_DONE;
  logic [1:0] dbg_state;

  int n_cmp;
  int n_fail;

  logic [3:0] exp_q[$];

  // Reference model: mode 0 idle, 1 waiting for settle, 2 offering a sample;
  // channel held as a number 1..4 (0 = none).
  int         m_mode;
  int         m_ch;
  int         m_left;
  logic [3:0] m_mask;
  bit         m_stop;
  bit         m_done;

  channel_sequencer #(.DWELL_WIDTH(8), .NUM_OF_SEL_BITS(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .CH_EN(CH_EN),
    .DWELL(DWELL), .SAMPLE_READY(SAMPLE_READY), .SEL(SEL), .CH_IDX(CH_IDX),
    .SAMPLE_VALID(SAMPLE_VALID), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
    .DBG_STATE(dbg_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int first_above(logic [3:0] m, int after);
    int r;
    r = 0;
    for (int c = 4; c > after; c--) begin
      if (m[c-1]) r = c;
    end
    return r;
  endfunction

  function automatic logic [8:0] model_vec();
    logic [3:0] s;
    logic [1:0] ix;
    s  = (m_ch == 0) ? 4'b0000 : 4'(1 << (m_ch - 1));
    ix = (m_ch == 0) ? 2'd0 : 2'(m_ch - 1);
    return {s, ix, (m_mode == 2), (m_mode != 0), m_done};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {SEL, CH_IDX, SAMPLE_VALID, BUSY, FRAME_DONE};
  endfunction

  task automatic model_step();
    int nxt;
    if (!RST_N) begin
      m_mode = 0; m_ch = 0; m_left = 0; m_mask = 4'b0; m_stop = 0; m_done = 0;
    end else begin
      m_done = 0;
      case (m_mode)
        0: begin
          m_stop = 0;
          if (START && CH_EN != 4'b0) begin
            m_mask = CH_EN; m_ch = first_above(CH_EN, 0); m_left = int'(DWELL); m_mode = 1;
          end
        end
        1: begin
          if (STOP) begin m_mode = 0; m_ch = 0; end
          else if (m_left == 0) m_mode = 2;
          else m_left = m_left - 1;
        end
        default: begin
          if (STOP) m_stop = 1;
          if (SAMPLE_READY) begin
            nxt = first_above(m_mask, m_ch);
            m_done = (nxt == 0);
            if (m_stop) begin
              m_mode = 0; m_ch = 0; m_stop = 0;
            end else if (nxt != 0) begin
              m_ch = nxt; m_left = int'(DWELL); m_mode = 1;
            end else begin
              m_mask = CH_EN;
              m_ch = first_above(CH_EN, 0);
              if (m_ch == 0) m_mode = 0;
              else begin m_left = int'(DWELL); m_mode = 1; end
            end
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; START = 1'b0; STOP = 1'b0; SAMPLE_READY = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b1; STOP = 1'b0; CH_EN = 4'hF; DWELL = 8'd2; SAMPLE_READY = 1'b1;
    tick(); tick();
    n_cmp++;
    if (dut_vec() !== 9'b0) begin
      n_fail++; $display("FAIL reset_outputs got=%b want=%b", dut_vec(), 9'b0);
    end
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL reset_model got=%b want=%b", dut_vec(), model_vec());
    end
    START = 1'b0; SAMPLE_READY = 1'b0; RST_N = 1'b1;
    tick();
  endtask

  task automatic test_invalid_start();
    CH_EN = 4'b0000; START = 1'b1; STOP = 1'b1; DWELL = 8'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (BUSY !== 1'b0 || SEL !== 4'b0000) begin
        n_fail++; $display("FAIL invalid_start busy=%b sel=%b want busy=0 sel=0000", BUSY, SEL);
      end
    end
    START = 1'b0; STOP = 1'b0;
  endtask

  task automatic test_full_frame();
    int budget, settle_len, dones;
    do_reset();
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    CH_EN = 4'b1111; DWELL = 8'd2; SAMPLE_READY = 1'b1; START = 1'b1;
    budget = 40; settle_len = 0; dones = 0;
    while (exp_q.size() > 0 && budget > 0) begin
      if (SAMPLE_VALID && SAMPLE_READY) begin
        n_cmp++;
        if (SEL !== exp_q[0]) begin
          n_fail++; $display("FAIL full_frame_sel got=%b want=%b", SEL, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      tick();
      START = 1'b0;
      budget--;
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL full_frame_model got=%b want=%b", dut_vec(), model_vec());
      end
      if (FRAME_DONE) dones++;
      if (BUSY && !SAMPLE_VALID) settle_len++;
      if (SAMPLE_VALID) begin
        n_cmp++;
        if (settle_len != 3) begin
          n_fail++; $display("FAIL full_frame_settle got=%0d want=3", settle_len);
        end
        settle_len = 0;
      end
    end
    n_cmp++;
    if (exp_q.size() != 0 || dones != 1) begin
      n_fail++; $display("FAIL full_frame_end left=%0d dones=%0d want left=0 dones=1", exp_q.size(), dones);
    end
  endtask

  task automatic test_backpressure();
    int budget, dones;
    do_reset();
    CH_EN = 4'b1010; DWELL = 8'd0; SAMPLE_READY = 1'b0; START = 1'b1;
    budget = 20;
    while (!SAMPLE_VALID && budget > 0) begin
      tick();
      START = 1'b0;
      budget--;
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL bp_start_model got=%b want=%b", dut_vec(), model_vec());
      end
    end
    n_cmp++;
    if (!SAMPLE_VALID) begin
      n_fail++; $display("FAIL bp_wait_valid got=0 want=1 (timeout)");
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (SEL !== 4'b0010 || SAMPLE_VALID !== 1'b1 || dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL bp_hold sel=%b valid=%b want sel=0010 valid=1", SEL, SAMPLE_VALID);
      end
    end
    exp_q = {4'b0010, 4'b1000, 4'b0010};
    SAMPLE_READY = 1'b1; budget = 20; dones = 0;
    while (exp_q.size() > 0 && budget > 0) begin
      if (SAMPLE_VALID && SAMPLE_READY) begin
        n_cmp++;
        if (SEL !== exp_q[0]) begin
          n_fail++; $display("FAIL bp_sel got=%b want=%b", SEL, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      tick();
      budget--;
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL bp_model got=%b want=%b", dut_vec(), model_vec());
      end
      if (FRAME_DONE) dones++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || dones != 1) begin
      n_fail++; $display("FAIL bp_end left=%0d dones=%0d want left=0 dones=1", exp_q.size(), dones);
    end
  endtask

  task automatic test_stop_in_sample();
    int budget, hs;
    do_reset();
    CH_EN = 4'b0101; DWELL = 8'd1; SAMPLE_READY = 1'b0; START = 1'b1;
    budget = 20;
    while (!SAMPLE_VALID && budget > 0) begin
      tick();
      START = 1'b0;
      budget--;
    end
    n_cmp++;
    if (!SAMPLE_VALID) begin
      n_fail++; $display("FAIL stop_wait_valid got=0 want=1 (timeout)");
    end
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    tick(); tick();
    n_cmp++;
    if (SAMPLE_VALID !== 1'b1 || SEL !== 4'b0001 || dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL stop_hold valid=%b sel=%b want valid=1 sel=0001", SAMPLE_VALID, SEL);
    end
    SAMPLE_READY = 1'b1; hs = 0;
    for (int i = 0; i < 4; i++) begin
      if (SAMPLE_VALID && SAMPLE_READY) hs++;
      tick();
      n_cmp++;
      if (BUSY !== 1'b0 || SEL !== 4'b0000 || dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL stop_idle busy=%b sel=%b want busy=0 sel=0000", BUSY, SEL);
      end
    end
    n_cmp++;
    if (hs != 1) begin
      n_fail++; $display("FAIL stop_handshakes got=%0d want=1", hs);
    end
    SAMPLE_READY = 1'b0;
  endtask

  task automatic test_mask_change();
    int budget, dones;
    do_reset();
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    CH_EN = 4'b1111; DWELL = 8'd1; SAMPLE_READY = 1'b1; START = 1'b1;
    budget = 40; dones = 0;
    tick();
    START = 1'b0;
    while (BUSY && budget > 0) begin
      if (SEL == 4'b0010) CH_EN = 4'b0000;
      if (SAMPLE_VALID && SAMPLE_READY) begin
        n_cmp++;
        if (exp_q.size() == 0 || SEL !== exp_q[0]) begin
          n_fail++; $display("FAIL mask_sel got=%b want=%b", SEL, (exp_q.size() == 0) ? 4'bxxxx : exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      tick();
      budget--;
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL mask_model got=%b want=%b", dut_vec(), model_vec());
      end
      if (FRAME_DONE) dones++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || dones != 1 || BUSY !== 1'b0 || SEL !== 4'b0000) begin
      n_fail++; $display("FAIL mask_end left=%0d dones=%0d busy=%b sel=%b want 0/1/0/0000",
                         exp_q.size(), dones, BUSY, SEL);
    end
  endtask

  task automatic test_reset_mid_settle();
    do_reset();
    CH_EN = 4'b1100; DWELL = 8'd200; SAMPLE_READY = 1'b1; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (BUSY !== 1'b1 || SEL !== 4'b0100) begin
      n_fail++; $display("FAIL rms_settle busy=%b sel=%b want busy=1 sel=0100", BUSY, SEL);
    end
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    n_cmp++;
    if (dut_vec() !== 9'b0 || dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL rms_reset got=%b want=%b", dut_vec(), 9'b0);
    end
    CH_EN = 4'b0110; DWELL = 8'd3; START = 1'b1;
    tick();
    START = 1'b0;
    n_cmp++;
    if (SEL !== 4'b0010 || CH_IDX !== 2'd1 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL rms_restart sel=%b idx=%0d busy=%b want sel=0010 idx=1 busy=1", SEL, CH_IDX, BUSY);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      RST_N        = ($urandom_range(0, 299) != 0);
      START        = ($urandom_range(0, 5) == 0);
      STOP         = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 9) == 0) CH_EN = 4'($urandom_range(0, 15));
      DWELL        = 8'($urandom_range(0, 3));
      SAMPLE_READY = ($urandom_range(0, 2) != 0);
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec() || $countones(SEL) > 1) begin
        n_fail++; $display("FAIL random_cycle%0d got=%b want=%b", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    m_mode = 0; m_ch = 0; m_left = 0; m_mask = 4'b0; m_stop = 0; m_done = 0;
    RST_N = 1'b0; START = 1'b0; STOP = 1'b0; CH_EN = 4'b0; DWELL = 8'd0; SAMPLE_READY = 1'b0;
    test_reset();
    test_invalid_start();
    test_full_frame();
    test_backpressure();
    test_stop_in_sample();
    test_mask_change();
    test_reset_mid_settle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
